// File: rtl/freq_ctrl_pkg.sv
// rtl/freq_ctrl_pkg.sv - shared state type, range constants and range helper functions for the measurement scheduler
package freq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_MEASURE,
      ST_EVAL,
      ST_HOLD
   } state_t;

   localparam int RANGE_W       = 2;
   localparam int NUM_RANGES    = 4;
   localparam int DEF_HI_THRESH = 999999;
   localparam int DEF_LO_THRESH = 100000;

   // Gate code is one-hot in the range: 1 ms, 10 ms, 100 ms, 1 s.
   function automatic logic [7:0] gate_code(input logic [RANGE_W-1:0] r);
      return 8'h01 << r;
   endfunction

   // Display unit is kHz, so the decimal point moves one digit per decade of gate.
   function automatic logic [5:0] dot_code(input logic [RANGE_W-1:0] r);
      return 6'b000001 << r;
   endfunction

endpackage

// File: rtl/freq_ctrl_timer.sv
// rtl/freq_ctrl_timer.sv - loadable down-counter with zero flag, shared by the settle, hold and watchdog intervals
module freq_ctrl_timer #(
   parameter int W = 32
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   // Load on state entry, otherwise count down and park at zero
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/freq_autorange_ctrl.sv
// rtl/freq_autorange_ctrl.sv - auto-ranging gated measurement scheduler; define FREQ_TIMEOUT_EN to add the MEASURE watchdog
import freq_ctrl_pkg::*;

module freq_autorange_ctrl #(
   parameter int CNT_W       = 24,
   parameter int HI_THRESH   = DEF_HI_THRESH,
   parameter int LO_THRESH   = DEF_LO_THRESH,
   parameter int SETTLE_CYC  = 16,
   parameter int HOLD_CYC    = 5000000,
   parameter int TIMEOUT_CYC = 60000000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             run,
   input  logic             manual_mode,
   input  logic [1:0]       manual_range,
   input  logic             meas_done,
   input  logic [CNT_W-1:0] meas_count,
   output logic             meas_oe,
   output logic [7:0]       gate_time,
   output logic [CNT_W-1:0] result,
   output logic [1:0]       result_range,
   output logic [5:0]       dot_sel,
   output logic             result_valid,
   output logic             overrange,
   output logic             timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0]   HI_C      = CNT_W'(HI_THRESH);
   localparam logic [CNT_W-1:0]   LO_C      = CNT_W'(LO_THRESH);
   localparam logic [RANGE_W-1:0] RANGE_MAX = RANGE_W'(NUM_RANGES - 1);
   localparam logic [31:0]        SETTLE_V  = 32'(SETTLE_CYC - 1);
   localparam logic [31:0]        HOLD_V    = 32'(HOLD_CYC - 1);
   localparam logic [31:0]        TMO_V     = 32'(TIMEOUT_CYC - 1);

   state_t             state_q, state_d;
   logic [RANGE_W-1:0] range_q, range_d;
   logic [CNT_W-1:0]   count_q;
   logic               meas_oe_q;
   logic [7:0]         gate_time_q;
   logic [CNT_W-1:0]   result_q;
   logic [1:0]         result_range_q;
   logic [5:0]         dot_sel_q;
   logic               result_valid_q, overrange_q, timeout_q, busy_q;

   logic               tmr_load, tmr_zero;
   logic [31:0]        tmr_val;
   logic               arm_entry, pub, pub_ovr, pub_tmo;
   logic               cnt_hi, cnt_lo;

   assign cnt_hi = (count_q > HI_C);
   assign cnt_lo = (count_q < LO_C);

   freq_ctrl_timer #(.W(32)) u_timer (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Next state, range stepping, publish decision and timer reloads
   always_comb begin
      state_d   = state_q;
      range_d   = range_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      pub       = 1'b0;
      pub_ovr   = 1'b0;
      pub_tmo   = 1'b0;
      arm_entry = 1'b0;
      if (!run) begin
         // Abort outranks everything, including a coincident meas_done.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
               if (tmr_zero) begin
                  state_d  = ST_MEASURE;
                  tmr_load = 1'b1;
                  tmr_val  = TMO_V;
               end
            end
            ST_MEASURE: begin
               if (meas_done) begin
                  state_d = ST_EVAL;
               end
`ifdef FREQ_TIMEOUT_EN
               else if (tmr_zero) begin
                  pub     = 1'b1;
                  pub_tmo = 1'b1;
               end
`endif
            end
            ST_EVAL: begin
               if (manual_mode) begin
                  pub     = 1'b1;
                  pub_ovr = cnt_hi;
               end else if (cnt_hi && range_q != '0) begin
                  range_d = range_q - RANGE_W'(1);
                  state_d = ST_ARM;
               end else if (cnt_hi) begin
                  pub     = 1'b1;
                  pub_ovr = 1'b1;
               end else if (cnt_lo && range_q != RANGE_MAX) begin
                  range_d = range_q + RANGE_W'(1);
                  state_d = ST_ARM;
               end else begin
                  pub = 1'b1;
               end
            end
            ST_HOLD: begin
               if (tmr_zero) begin
                  state_d = ST_ARM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (pub) begin
         state_d  = ST_HOLD;
         tmr_load = 1'b1;
         tmr_val  = HOLD_V;
      end
      if (state_d == ST_ARM && state_q != ST_ARM) begin
         // Manual range is only sampled here, so switch changes apply at the next arm.
         arm_entry = 1'b1;
         if (manual_mode) begin
            range_d = manual_range;
         end
         tmr_load = 1'b1;
         tmr_val  = SETTLE_V;
      end
   end

   // State register and all registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q        <= ST_IDLE;
         range_q        <= RANGE_MAX;
         count_q        <= '0;
         meas_oe_q      <= 1'b0;
         gate_time_q    <= 8'h08;
         result_q       <= '0;
         result_range_q <= '0;
         dot_sel_q      <= 6'b000001;
         result_valid_q <= 1'b0;
         overrange_q    <= 1'b0;
         timeout_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         range_q        <= range_d;
         busy_q         <= (state_d != ST_IDLE);
         meas_oe_q      <= (state_d == ST_MEASURE);
         result_valid_q <= pub;
         if (arm_entry) begin
            gate_time_q <= gate_code(range_d);
         end
         if (state_q == ST_MEASURE && state_d == ST_EVAL) begin
            count_q <= meas_count;
         end
         if (pub) begin
            result_q       <= pub_tmo ? '0 : count_q;
            result_range_q <= range_q;
            dot_sel_q      <= dot_code(range_q);
            overrange_q    <= pub_ovr;
            timeout_q      <= pub_tmo;
         end
      end
   end

   assign meas_oe      = meas_oe_q;
   assign gate_time    = gate_time_q;
   assign result       = result_q;
   assign result_range = result_range_q;
   assign dot_sel      = dot_sel_q;
   assign result_valid = result_valid_q;
   assign overrange    = overrange_q;
   assign timeout      = timeout_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_freq_autorange_ctrl.sv
// tb/tb_freq_autorange_ctrl.sv - scoreboard bench for freq_autorange_ctrl with an emulated pulse counter
module tb_freq_autorange_ctrl;

   localparam int HI   = 999999;
   localparam int LO   = 100000;
   localparam int CMAX = 16777215;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        run = 1'b0;
   logic        manual_mode = 1'b0;
   logic [1:0]  manual_range = 2'd0;
   logic        rsp_done = 1'b0;
   logic        tst_done = 1'b0;
   logic [23:0] rsp_count = '0;
   logic [23:0] tst_count = '0;
   logic        meas_done;
   logic [23:0] meas_count;
   logic        meas_oe;
   logic [7:0]  gate_time;
   logic [23:0] result;
   logic [1:0]  result_range;
   logic [5:0]  dot_sel;
   logic        result_valid, overrange, timeout, busy;

   assign meas_done  = rsp_done | tst_done;
   assign meas_count = tst_done ? tst_count : rsp_count;

   typedef struct {
      int res;
      int rng;
      int ovr;
      int tmo;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   exp_t       last_exp = '{0, 0, 0, 0};
   logic [7:0] exp_gate[$];
   int         tab[4];
   bit         resp_en = 1'b0;
   int         model_range = 3;
   int         checks = 0;
   int         failures = 0;
   int         pub_cnt = 0;

   freq_autorange_ctrl #(
      .SETTLE_CYC  (4),
      .HOLD_CYC    (8),
      .TIMEOUT_CYC (50)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .run          (run),
      .manual_mode  (manual_mode),
      .manual_range (manual_range),
      .meas_done    (meas_done),
      .meas_count   (meas_count),
      .meas_oe      (meas_oe),
      .gate_time    (gate_time),
      .result       (result),
      .result_range (result_range),
      .dot_sel      (dot_sel),
      .result_valid (result_valid),
      .overrange    (overrange),
      .timeout      (timeout),
      .busy         (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard monitor: every publish strobe consumes one expected result
   always @(negedge sys_clk) begin
      if (sys_rst && result_valid) begin
         pub_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_result_valid", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", result, mon_e.res);
            chk("result_range", result_range, mon_e.rng);
            chk("dot_sel", dot_sel, 1 << mon_e.rng);
            chk("overrange", overrange, mon_e.ovr);
            chk("timeout", timeout, mon_e.tmo);
            last_exp = mon_e;
         end
      end
   end

   // Counter emulation: answers each gated measurement with the count for the gate in use
   initial begin : responder
      int r;
      int dly;
      logic [7:0] eg;
      forever begin
         @(negedge sys_clk);
         if (resp_en && meas_oe) begin
            if (exp_gate.size() == 0) begin
               chk("unexpected_measurement", 1, 0);
            end else begin
               eg = exp_gate.pop_front();
               chk("gate_time", gate_time, eg);
            end
            r = 0;
            for (int i = 0; i < 4; i++) begin
               if (gate_time == (8'h01 << i)) r = i;
            end
            dly = $urandom_range(1, 6);
            repeat (dly) @(negedge sys_clk);
            if (resp_en && meas_oe) begin
               rsp_count = 24'(tab[r]);
               rsp_done  = 1'b1;
               @(negedge sys_clk);
               rsp_done  = 1'b0;
            end
            for (int k = 0; k < 100 && meas_oe; k++) @(negedge sys_clk);
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_meas_oe"}, meas_oe, 0);
      chk({tag, "_gate_time"}, gate_time, 8);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_result_range"}, result_range, 0);
      chk({tag, "_dot_sel"}, dot_sel, 1);
      chk({tag, "_result_valid"}, result_valid, 0);
      chk({tag, "_overrange"}, overrange, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic wait_pub(input int n0);
      int k;
      k = 0;
      while (pub_cnt == n0 && k < 3000) begin
         @(negedge sys_clk);
         k++;
      end
      if (pub_cnt == n0) chk("publish_wait_expired", 0, 1);
   endtask

   task automatic wait_oe();
      int k;
      k = 0;
      while (!meas_oe && k < 200) begin
         @(negedge sys_clk);
         k++;
      end
      if (!meas_oe) chk("meas_oe_wait_expired", 0, 1);
   endtask

   // Reference: walk the ranges by the auto-range rules until a publish, using the counter table
   task automatic run_scenario(input bit man, input logic [1:0] mr,
                               input int t0, input int t1, input int t2, input int t3);
      int   r;
      int   c;
      int   n0;
      bit   done;
      exp_t e;
      tab[0] = t0; tab[1] = t1; tab[2] = t2; tab[3] = t3;
      manual_mode  = man;
      manual_range = mr;
      r    = man ? int'(mr) : model_range;
      done = 1'b0;
      e    = '{0, 0, 0, 0};
      for (int s = 0; s < 8 && !done; s++) begin
         exp_gate.push_back(8'(1 << r));
         c = tab[r];
         if (man) begin
            e = '{c, r, (c > HI) ? 1 : 0, 0};
            done = 1'b1;
         end else if (c > HI && r > 0) begin
            r--;
         end else if (c > HI) begin
            e = '{c, r, 1, 0};
            done = 1'b1;
         end else if (c < LO && r < 3) begin
            r++;
         end else begin
            e = '{c, r, 0, 0};
            done = 1'b1;
         end
      end
      exp_q.push_back(e);
      model_range = r;
      resp_en = 1'b1;
      n0  = pub_cnt;
      run = 1'b1;
      wait_pub(n0);
      run = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk("idle_busy", busy, 0);
      chk("idle_meas_oe", meas_oe, 0);
      chk("gate_queue_drained", exp_gate.size(), 0);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL global_watchdog actual=running required=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin : stim
      int     n0;
      longint v;
      int     t[4];
      bit     man;
      logic [1:0] mr;
      int     f;

      repeat (3) @(negedge sys_clk);
      chk_reset("rst");
      sys_rst = 1'b1;
      @(negedge sys_clk);

      // Directed auto-range cases
      run_scenario(1'b0, 2'd0, 5000, 50000, 500000, 5000000);
      run_scenario(1'b0, 2'd0, 1, 12, 120, 1200);
      run_scenario(1'b0, 2'd0, 2000000, 2000000, 2000000, 2000000);
      run_scenario(1'b0, 2'd0, 50, 50, 50, 50);

      // Manual range, re-sampled at the next arm after a change during HOLD
      tab[0] = 42; tab[1] = 42; tab[2] = 42; tab[3] = 42;
      manual_mode  = 1'b1;
      manual_range = 2'd1;
      exp_gate.push_back(8'h02);
      exp_q.push_back('{42, 1, 0, 0});
      exp_gate.push_back(8'h04);
      exp_q.push_back('{42, 2, 0, 0});
      resp_en = 1'b1;
      n0  = pub_cnt;
      run = 1'b1;
      wait_pub(n0);
      manual_range = 2'd2;
      wait_pub(n0 + 1);
      run = 1'b0;
      model_range = 2;
      repeat (2) @(negedge sys_clk);
      chk("manual_idle_busy", busy, 0);
      manual_mode = 1'b0;

      // Abort coinciding with meas_done
      resp_en = 1'b0;
      n0  = pub_cnt;
      run = 1'b1;
      wait_oe();
      chk("abort_gate_time", gate_time, 1 << model_range);
      @(negedge sys_clk);
      run       = 1'b0;
      tst_count = 24'd777;
      tst_done  = 1'b1;
      @(negedge sys_clk);
      tst_done  = 1'b0;
      chk("abort_meas_oe", meas_oe, 0);
      chk("abort_busy", busy, 0);
      repeat (20) @(negedge sys_clk);
      chk("abort_no_valid", pub_cnt, n0);
      chk("abort_result_kept", result, last_exp.res);
      chk("abort_range_kept", result_range, last_exp.rng);

      // Counter that never answers
      n0  = pub_cnt;
      run = 1'b1;
      wait_oe();
`ifdef FREQ_TIMEOUT_EN
      begin
         int n;
         n = 0;
         exp_q.push_back('{0, model_range, 0, 1});
         while (!result_valid && n < 200) begin
            @(negedge sys_clk);
            n++;
         end
         chk("timeout_latency", n, 50);
         @(negedge sys_clk);
         chk("timeout_hold_busy", busy, 1);
         chk("timeout_hold_meas_oe", meas_oe, 0);
      end
`else
      repeat (100) @(negedge sys_clk);
      chk("no_watchdog_meas_oe", meas_oe, 1);
      chk("no_watchdog_timeout", timeout, 0);
      chk("no_watchdog_valid", pub_cnt, n0);
`endif
      run = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk("post_wait_busy", busy, 0);

      // Randomized physical inputs: count scales by ten per range, saturating at the counter width
      for (int it = 0; it < 12; it++) begin
         man = ($urandom_range(0, 3) == 0);
         mr  = 2'($urandom_range(0, 3));
         f   = $urandom_range(1, 99999) >> $urandom_range(0, 16);
         v   = f;
         for (int r = 0; r < 4; r++) begin
            t[r] = (v > CMAX) ? CMAX : int'(v);
            v = v * 10;
         end
         run_scenario(man, mr, t[0], t[1], t[2], t[3]);
      end
      manual_mode = 1'b0;

      // Asynchronous reset in the middle of a measurement
      resp_en = 1'b0;
      run = 1'b1;
      wait_oe();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      run = 1'b0;
      #1;
      chk_reset("midrst");
      @(negedge sys_clk);
      sys_rst = 1'b1;
      model_range = 3;

      // Reset must have restored the top range
      run_scenario(1'b0, 2'd0, 300, 3000, 30000, 300000);

      chk("scoreboard_drained", exp_q.size(), 0);
      chk("gate_queue_final", exp_gate.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/freq_autorange_ctrl.md
Name: freq_autorange_ctrl

Overview:
Measurement scheduler for the pulse counter datapath. It sequences repeated gated measurements by driving the counter's OE and gate_time, then evaluates each returned count. In auto mode it steps the gate range until the count fits a 6-digit display; in manual mode it uses the range from the switches. It publishes a registered result with range code and decimal-point select for the display and hex-to-dec path.

Parameters:
- CNT_W, 24, width of the counter result.
- HI_THRESH, 999999, count above this means too long a gate (display overflow).
- LO_THRESH, 100000, count below this means too short a gate (lost resolution).
- SETTLE_CYC, 16, sys_clk cycles gate_time is held stable before OE rises.
- HOLD_CYC, 5000000, idle cycles between published measurements.
- TIMEOUT_CYC, 60000000, watchdog limit in MEASURE (FREQ_TIMEOUT_EN only).

Ports:
- sys_clk, in, 1, system clock.
- sys_rst, in, 1, asynchronous active-low reset.
- run, in, 1, level; 1 = measure continuously, 0 = abort and idle.
- manual_mode, in, 1, 1 = use manual_range, 0 = auto-range.
- manual_range, in, 2, range for manual mode.
- meas_done, in, 1, one-cycle pulse from the counter when its count is valid.
- meas_count, in, CNT_W, counter result; sampled only when meas_done = 1.
- meas_oe, out, 1, counter enable.
- gate_time, out, 8, gate code to the counter.
- result, out, CNT_W, last published count.
- result_range, out, 2, range of the published result.
- dot_sel, out, 6, decimal-point select for the display.
- result_valid, out, 1, one-cycle strobe on publish.
- overrange, out, 1, published count exceeds HI_THRESH at range 0.
- timeout, out, 1, published result came from the watchdog.
- busy, out, 1, state ≠ IDLE.

Behaviour:
- Reset values: state IDLE; range = 3; meas_oe = 0; gate_time = 8'h08; result = 0; result_range = 0; dot_sel = 6'b000001; result_valid, overrange, timeout and busy = 0.
- Range-to-gate mapping: range r → gate_time = 8'h01 << r, giving 1 ms, 10 ms, 100 ms and 1 s.
- Decimal point: dot_sel = 6'b1 << result_range. The display unit is kHz.
- States: IDLE, ARM, MEASURE, EVAL, HOLD. All outputs are registered.
- IDLE:
  - run = 1 → ARM.
  - On ARM entry the working range is loaded: manual_range if manual_mode = 1, otherwise it is kept.
- ARM:
  - gate_time is driven from the working range and meas_oe = 0.
  - After SETTLE_CYC cycles → MEASURE.
  - manual_range is re-sampled on every ARM entry; changes at any other time take effect at the next ARM.
- MEASURE:
  - meas_oe = 1.
  - On meas_done: latch meas_count, set meas_oe = 0 the next cycle → EVAL.
  - A meas_done seen in any other state is ignored.
- EVAL (1 cycle, auto mode):
  - count > HI_THRESH and range > 0 → range−1, discard, → ARM.
  - count > HI_THRESH and range = 0 → publish with overrange = 1.
  - count < LO_THRESH and range < 3 → range+1, discard, → ARM.
  - Otherwise publish.
- EVAL (manual mode): always publish; overrange = 1 if count > HI_THRESH.
- Publish: in one cycle, load result, result_range, dot_sel, overrange and timeout; pulse result_valid; → HOLD.
- HOLD: wait HOLD_CYC cycles → ARM.
- Thresholds are a decade apart, so auto-range hunting is impossible with a stable input; no retry limit is needed.
- run = 0 in any state → IDLE next cycle with meas_oe = 0. Published outputs are retained and no result_valid is generated.
- Asynchronous reset mid-measurement clears everything immediately; meas_oe drops asynchronously.
- Simultaneous run falling and meas_done: abort wins and the count is discarded.
- Comparisons are unsigned at CNT_W width.

Optional Feature:
- FREQ_TIMEOUT_EN defined: MEASURE runs a watchdog. After TIMEOUT_CYC cycles without meas_done:
  - meas_oe drops;
  - result = 0 is published with timeout = 1 and overrange = 0;
  - range is unchanged;
  - state → HOLD.
- FREQ_TIMEOUT_EN undefined: MEASURE waits indefinitely and timeout is tied to 0.

Decomposition:
- Package freq_ctrl_pkg holds:
  - the state enum;
  - the range width constant (2) and NUM_RANGES = 4;
  - the gate-code and dot-select functions of range;
  - the default HI/LO thresholds.
- One sub-module, freq_ctrl_timer: a loadable down-counter with a zero flag, shared for SETTLE, HOLD and TIMEOUT. Only one timer is ever active per state.

Test Plan:
- Bench settings: SETTLE_CYC = 4, HOLD_CYC = 8, TIMEOUT_CYC = 50.
- Auto, start range 3, counter returns 5000000 then 500000 → one range step down. Require gate_time 8'h08 → 8'h04, then result_valid with result = 500000, result_range = 2, dot_sel = 6'b000100.
- Auto, counter returns 1200 at range 3 → require result = 1200, result_range = 3, no range change. Then returns 50 at range 0 → require range steps up through 1, 2, 3 before publishing.
- Auto, counter returns 2000000 at every range → require three discards down to range 0, then publish with overrange = 1 and dot_sel = 6'b000001.
- Manual, manual_range = 1, count 42 → require publish with result = 42 and result_range = 1, no auto step. Change manual_range to 2 during HOLD → require the next gate_time = 8'h04.
- Abort and reset: deassert run mid-MEASURE in the same cycle as meas_done → require meas_oe = 0 next cycle, IDLE, and no result_valid. Pulse sys_rst low mid-MEASURE → require all outputs return to their reset values.
- With FREQ_TIMEOUT_EN, no meas_done → require that 50 cycles after meas_oe rises, result = 0, timeout = 1 and result_valid pulses, followed by HOLD.
